utf8_stream_decoder: RTL and testbench

Streaming UTF-8 to code-point decoder with valid/ready handshakes on both sides. It accepts one byte per cycle and decodes sequences of up to MAX_LEN bytes. Each decoded unit is classified (overlong, invalid, out-of-range, truncated), with optional substitution of U+FFFD, and queued in a DEPTH-entry output FIFO. It is the next generation of the single-character converter: it carries the same classification rules but processes a continuous stream with backpressure, which lets it sit between a byte FIFO and character consumers.

---
 rtl/utf8_stream_decoder.sv | 169 ++++++++++++++++
 tb/tb_utf8_stream_decoder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 byte-to-code-point decoder with per-unit error classification
// and a small output FIFO; valid/ready handshakes on both the byte and code-point sides.
module utf8_stream_decoder #(
  parameter int MAX_LEN    = 4,
  parameter int CHK_RANGE  = 1,
  parameter int ALLOW_SURR = 0,
  parameter int REPLACE    = 1,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [30:0]   out_cp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_err,
  output logic          out_trunc,
  output logic          out_invalid,
  output logic          out_overlong,
  output logic          out_nonuni,
  output logic          pending,
  output logic [AW:0]   count
);

  typedef enum logic {IDLE, CONT} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t      state, state_nx;
  logic [30:0] acc, acc_nx;
  logic [2:0]  need, need_nx, len, len_nx;

  // Flag order in storage: {trunc, invalid, overlong, nonuni}
  logic [30:0] mem_cp [DEPTH];
  logic [3:0]  mem_fl [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  logic        full, is_cont, accept, pop, push, push_err;
  logic [30:0] push_val, store_cp, cat;
  logic [3:0]  push_fl;

  function automatic logic [3:0] classify(input logic [30:0] v, input logic [2:0] l);
    logic [30:0] min_v;
    case (l)
      3'd2:    min_v = 31'h80;
      3'd3:    min_v = 31'h800;
      3'd4:    min_v = 31'h10000;
      3'd5:    min_v = 31'h200000;
      default: min_v = 31'h4000000;
    endcase
    if (v < min_v) return 4'b0010;
    if (ALLOW_SURR == 0 && v >= 31'hD800 && v <= 31'hDFFF) return 4'b0100;
    if (v > 31'h10FFFF) return 4'b0001;
    return 4'b0000;
  endfunction

  always_comb begin
    full     = (cnt == FULL_CNT);
    is_cont  = (in_data[7:6] == 2'b10);
    in_ready = rst_in & ~full & ~((state == CONT) & in_valid & ~is_cont);
    accept   = in_valid & in_ready;
    pop      = (cnt != '0) & out_ready;
    cat      = {acc[24:0], in_data[5:0]};

    push     = 1'b0;
    push_val = {23'b0, in_data};
    push_fl  = 4'b0000;
    state_nx = state;
    acc_nx   = acc;
    need_nx  = need;
    len_nx   = len;

    if (state == IDLE) begin
      if (accept) begin
        if (!in_data[7]) begin
          push = 1'b1;
        end else if (in_data[7:6] == 2'b10) begin
          push    = 1'b1;
          push_fl = 4'b0100;
        end else if (in_data[7:5] == 3'b110) begin
          state_nx = CONT; len_nx = 3'd2; need_nx = 3'd1; acc_nx = {26'b0, in_data[4:0]};
        end else if (in_data[7:4] == 4'b1110) begin
          state_nx = CONT; len_nx = 3'd3; need_nx = 3'd2; acc_nx = {27'b0, in_data[3:0]};
        end else if (in_data[7:3] == 5'b11110) begin
          state_nx = CONT; len_nx = 3'd4; need_nx = 3'd3; acc_nx = {28'b0, in_data[2:0]};
        end else if (MAX_LEN == 6 && in_data[7:2] == 6'b111110) begin
          state_nx = CONT; len_nx = 3'd5; need_nx = 3'd4; acc_nx = {29'b0, in_data[1:0]};
        end else if (MAX_LEN == 6 && in_data[7:1] == 7'b1111110) begin
          state_nx = CONT; len_nx = 3'd6; need_nx = 3'd5; acc_nx = {30'b0, in_data[0]};
        end else begin
          push    = 1'b1;
          push_fl = 4'b0100;
        end
      end
    end else begin
      if (accept) begin
        acc_nx  = cat;
        need_nx = need - 3'd1;
        if (need == 3'd1) begin
          push     = 1'b1;
          push_val = cat;
          push_fl  = classify(cat, len);
          state_nx = IDLE;
          acc_nx   = '0;
          len_nx   = '0;
        end
      end else if (~full & ((in_valid & ~is_cont) | (~in_valid & flush))) begin
        // Offending byte stays on the bus and is decoded from IDLE next cycle.
        push     = 1'b1;
        push_val = acc;
        push_fl  = 4'b1000;
        state_nx = IDLE;
        acc_nx   = '0;
        need_nx  = '0;
        len_nx   = '0;
      end
    end

    push_err = push_fl[3] | push_fl[2] | push_fl[1] | (push_fl[0] & (CHK_RANGE != 0));
    store_cp = (REPLACE != 0 && push_err) ? 31'hFFFD : push_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state  <= IDLE;
      acc    <= '0;
      need   <= '0;
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      need  <= need_nx;
      len   <= len_nx;
      if (push) begin
        mem_cp[wr_ptr] <= store_cp;
        mem_fl[wr_ptr] <= push_fl;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head fields are masked so an empty FIFO presents all zeros.
  always_comb begin
    out_valid    = (cnt != '0);
    count        = cnt;
    pending      = (state == CONT);
    out_cp       = out_valid ? mem_cp[rd_ptr] : '0;
    out_trunc    = out_valid & mem_fl[rd_ptr][3];
    out_invalid  = out_valid & mem_fl[rd_ptr][2];
    out_overlong = out_valid & mem_fl[rd_ptr][1];
    out_nonuni   = out_valid & mem_fl[rd_ptr][0];
    out_err      = out_trunc | out_invalid | out_overlong | (out_nonuni & (CHK_RANGE != 0));
  end

endmodule

// File: tb/tb_utf8_stream_decoder.sv
// Bench for utf8_stream_decoder: two instances (replace+range-check on, both off)
// share one byte stream; outputs are compared to constants and to a sequence-level model.
module tb_utf8_stream_decoder;

  logic        clk, rst_in, in_valid, flush, out_ready;
  logic [7:0]  in_data;
  logic        in_ready1, out_valid1, out_err1, out_trunc1, out_invalid1, out_overlong1, out_nonuni1, pending1;
  logic        in_ready2, out_valid2, out_err2, out_trunc2, out_invalid2, out_overlong2, out_nonuni2, pending2;
  logic [30:0] out_cp1, out_cp2;
  logic [2:0]  count1, count2;

  utf8_stream_decoder #(.MAX_LEN(4), .CHK_RANGE(1), .ALLOW_SURR(0), .REPLACE(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst_in(rst_in), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .flush(flush), .out_cp(out_cp1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_err(out_err1), .out_trunc(out_trunc1), .out_invalid(out_invalid1),
    .out_overlong(out_overlong1), .out_nonuni(out_nonuni1), .pending(pending1), .count(count1));

  utf8_stream_decoder #(.MAX_LEN(4), .CHK_RANGE(0), .ALLOW_SURR(0), .REPLACE(0), .DEPTH(4)) dut2 (
    .clk(clk), .rst_in(rst_in), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .flush(flush), .out_cp(out_cp2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_err(out_err2), .out_trunc(out_trunc2), .out_invalid(out_invalid2),
    .out_overlong(out_overlong2), .out_nonuni(out_nonuni2), .pending(pending2), .count(count2));

  int total = 0;
  int bad = 0;
  int waits = 0;
  int ready_mode = 1;

  logic [30:0] obs_cp1[$], obs_cp2[$], exp_cp1[$], exp_cp2[$];
  logic [4:0]  obs_fl1[$], obs_fl2[$], exp_fl1[$], exp_fl2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer: picks out_ready each cycle and records every popped head.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rst_in && out_ready) begin
        if (out_valid1) begin
          obs_cp1.push_back(out_cp1);
          obs_fl1.push_back({out_err1, out_trunc1, out_invalid1, out_overlong1, out_nonuni1});
        end
        if (out_valid2) begin
          obs_cp2.push_back(out_cp2);
          obs_fl2.push_back({out_err2, out_trunc2, out_invalid2, out_overlong2, out_nonuni2});
        end
      end
    end
  end

  task automatic clear_obs();
    obs_cp1.delete(); obs_fl1.delete(); obs_cp2.delete(); obs_fl2.delete();
  endtask

  // Items >= 0 are bytes; -1 means assert flush until the sequence is closed.
  task automatic send(input int items[$]);
    int n;
    foreach (items[k]) begin
      if (items[k] < 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (pending1 && n < 200);
        flush = 1'b0;
        total++;
        if (pending1) begin
          bad++;
          $display("FAIL flush_timeout pending=%b required 0", pending1);
        end
      end else begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'(items[k]);
        flush = 1'b0;
        n = 0;
        #1;
        while (!in_ready1 && n < 200) begin
          waits++;
          @(negedge clk);
          #1;
          n++;
        end
        total++;
        if (!in_ready1) begin
          bad++;
          $display("FAIL byte_timeout byte=%h in_ready=%b required 1", in_data, in_ready1);
        end
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((out_valid1 || out_valid2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2;
    total++;
    if (out_valid1 || out_valid2) begin
      bad++;
      $display("FAIL drain_timeout out_valid=%b/%b required 0/0", out_valid1, out_valid2);
    end
  endtask

  // Sequence-level reference: decodes with plain arithmetic, then applies the
  // error/replacement rules for each instance's configuration.
  task automatic model_run(input int items[$]);
    int raw_cp[$], raw_kind[$];  // kind: 0 ok, 1 trunc, 2 invalid, 3 overlong, 4 nonuni
    int i = 0, acc = 0, need = 0, len = 0, b, ones, min_v;
    bit in_seq = 0, err;
    while (i < items.size()) begin
      b = items[i];
      if (b < 0) begin
        if (in_seq) begin raw_cp.push_back(acc); raw_kind.push_back(1); in_seq = 0; end
        i++;
      end else if (in_seq) begin
        if (b >= 128 && b < 192) begin
          acc = acc * 64 + (b % 64);
          need--;
          if (need == 0) begin
            min_v = (len == 2) ? 'h80 : (len == 3) ? 'h800 : 'h10000;
            raw_cp.push_back(acc);
            if (acc < min_v) raw_kind.push_back(3);
            else if (acc >= 'hD800 && acc <= 'hDFFF) raw_kind.push_back(2);
            else if (acc > 'h10FFFF) raw_kind.push_back(4);
            else raw_kind.push_back(0);
            in_seq = 0;
          end
          i++;
        end else begin
          raw_cp.push_back(acc); raw_kind.push_back(1); in_seq = 0;
        end
      end else begin
        ones = (b < 'h80) ? 0 : (b < 'hC0) ? 1 : (b < 'hE0) ? 2 : (b < 'hF0) ? 3 : (b < 'hF8) ? 4 : 5;
        if (ones == 0) begin
          raw_cp.push_back(b); raw_kind.push_back(0);
        end else if (ones >= 2 && ones <= 4) begin
          len = ones; need = ones - 1; acc = b % (1 << (7 - ones)); in_seq = 1;
        end else begin
          raw_cp.push_back(b); raw_kind.push_back(2);
        end
        i++;
      end
    end
    exp_cp1.delete(); exp_fl1.delete(); exp_cp2.delete(); exp_fl2.delete();
    foreach (raw_cp[k]) begin
      err = raw_kind[k] inside {1, 2, 3} || raw_kind[k] == 4;
      exp_cp1.push_back(err ? 31'hFFFD : 31'(raw_cp[k]));
      exp_fl1.push_back({err, raw_kind[k] == 1, raw_kind[k] == 2, raw_kind[k] == 3, raw_kind[k] == 4});
      err = raw_kind[k] inside {1, 2, 3};
      exp_cp2.push_back(31'(raw_cp[k]));
      exp_fl2.push_back({err, raw_kind[k] == 1, raw_kind[k] == 2, raw_kind[k] == 3, raw_kind[k] == 4});
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; in_valid = 1'b1; in_data = 8'h41; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (in_ready1 !== 1'b0 || in_ready2 !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got %b/%b required 0/0", in_ready1, in_ready2);
    end
    total++;
    if (out_valid1 !== 1'b0 || count1 !== 3'd0 || pending1 !== 1'b0) begin
      bad++; $display("FAIL reset_status valid=%b count=%0d pending=%b required 0 0 0", out_valid1, count1, pending1);
    end
    total++;
    if (out_cp1 !== 31'h0 || {out_err1, out_trunc1, out_invalid1, out_overlong1, out_nonuni1} !== 5'b0) begin
      bad++; $display("FAIL reset_head cp=%h err=%b required cp=0 flags=0", out_cp1, out_err1);
    end
    in_valid = 1'b0;
    rst_in = 1'b1;
  endtask

  task automatic test_ascii();
    ready_mode = 0;
    clear_obs();
    send('{8'h41});
    total++;
    if (out_valid1 !== 1'b1 || count1 !== 3'd1) begin
      bad++; $display("FAIL ascii_latency out_valid=%b count=%0d required 1 1", out_valid1, count1);
    end
    send('{8'h7F});
    ready_mode = 1;
    wait_drain();
    total++;
    if (obs_cp1.size() != 2 || obs_cp2.size() != 2) begin
      bad++; $display("FAIL ascii_count got %0d/%0d required 2", obs_cp1.size(), obs_cp2.size());
    end else begin
      total++;
      if (obs_cp1[0] !== 31'h41 || obs_cp1[1] !== 31'h7F || obs_fl1[0] !== 5'b0 || obs_fl1[1] !== 5'b0 ||
          obs_cp2[0] !== 31'h41 || obs_cp2[1] !== 31'h7F) begin
        bad++; $display("FAIL ascii_values got %h %h required 41 7f flags 0", obs_cp1[0], obs_cp1[1]);
      end
    end
  endtask

  task automatic test_multibyte();
    logic [30:0] e1_cp [6] = '{31'h20AC, 31'h1F600, 31'hFFFD, 31'hFFFD, 31'hFFFD, 31'hFFFD};
    logic [4:0]  e1_fl [6] = '{5'b00000, 5'b00000, 5'b10010, 5'b10100, 5'b10001, 5'b10100};
    logic [30:0] e2_cp [6] = '{31'h20AC, 31'h1F600, 31'h0, 31'hD800, 31'h110000, 31'hF8};
    logic [4:0]  e2_fl [6] = '{5'b00000, 5'b00000, 5'b10010, 5'b10100, 5'b00001, 5'b10100};
    ready_mode = 1;
    clear_obs();
    send('{8'hE2, 8'h82, 8'hAC, 8'hF0, 8'h9F});
    #1;
    total++;
    if (pending1 !== 1'b1) begin
      bad++; $display("FAIL multi_pending got %b required 1", pending1);
    end
    send('{8'h98, 8'h80, 8'hC0, 8'h80, 8'hED, 8'hA0, 8'h80, 8'hF4, 8'h90, 8'h80, 8'h80, 8'hF8});
    wait_drain();
    total++;
    if (pending1 !== 1'b0) begin
      bad++; $display("FAIL multi_idle pending=%b required 0", pending1);
    end
    total++;
    if (obs_cp1.size() != 6 || obs_cp2.size() != 6) begin
      bad++; $display("FAIL multi_count got %0d/%0d required 6", obs_cp1.size(), obs_cp2.size());
    end
    for (int i = 0; i < 6 && i < obs_cp1.size() && i < obs_cp2.size(); i++) begin
      total++;
      if (obs_cp1[i] !== e1_cp[i] || obs_fl1[i] !== e1_fl[i]) begin
        bad++; $display("FAIL multi_rep[%0d] got cp=%h fl=%b required cp=%h fl=%b", i, obs_cp1[i], obs_fl1[i], e1_cp[i], e1_fl[i]);
      end
      total++;
      if (obs_cp2[i] !== e2_cp[i] || obs_fl2[i] !== e2_fl[i]) begin
        bad++; $display("FAIL multi_raw[%0d] got cp=%h fl=%b required cp=%h fl=%b", i, obs_cp2[i], obs_fl2[i], e2_cp[i], e2_fl[i]);
      end
    end
  endtask

  task automatic test_trunc();
    logic [30:0] e2_cp [3] = '{31'h82, 31'h41, 31'h2};
    logic [4:0]  e_fl  [3] = '{5'b11000, 5'b00000, 5'b11000};
    ready_mode = 1;
    clear_obs();
    waits = 0;
    send('{8'hE2, 8'h82, 8'h41});
    total++;
    if (waits != 1) begin
      bad++; $display("FAIL trunc_stall got %0d stall cycles required 1", waits);
    end
    send('{8'hE2, -1});
    wait_drain();
    total++;
    if (obs_cp1.size() != 3 || obs_cp2.size() != 3) begin
      bad++; $display("FAIL trunc_count got %0d/%0d required 3", obs_cp1.size(), obs_cp2.size());
    end
    for (int i = 0; i < 3 && i < obs_cp1.size() && i < obs_cp2.size(); i++) begin
      total++;
      if (obs_cp1[i] !== (i == 1 ? 31'h41 : 31'hFFFD) || obs_fl1[i] !== e_fl[i] ||
          obs_cp2[i] !== e2_cp[i] || obs_fl2[i] !== e_fl[i]) begin
        bad++; $display("FAIL trunc_entry[%0d] got cp=%h/%h fl=%b/%b required cp2=%h fl=%b", i, obs_cp1[i], obs_cp2[i], obs_fl1[i], obs_fl2[i], e2_cp[i], e_fl[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    logic [30:0] head;
    ready_mode = 0;
    clear_obs();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (accepted < 6);
      in_data = 8'h41;
      #1;
      if (in_valid && in_ready1) accepted++;
    end
    @(negedge clk);
    #1;
    head = out_cp1;
    total++;
    if (accepted != 4 || count1 !== 3'd4 || in_ready1 !== 1'b0) begin
      bad++; $display("FAIL bp_full accepted=%0d count=%0d in_ready=%b required 4 4 0", accepted, count1, in_ready1);
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (out_cp1 !== head || out_valid1 !== 1'b1 || out_cp1 !== 31'h41) begin
      bad++; $display("FAIL bp_head_stable got %h valid=%b required 41 valid=1", out_cp1, out_valid1);
    end
    in_valid = 1'b0;
    ready_mode = 1;
    send('{8'h41, 8'h41});
    wait_drain();
    total++;
    if (obs_cp1.size() != 6 || obs_cp2.size() != 6) begin
      bad++; $display("FAIL bp_count got %0d/%0d required 6", obs_cp1.size(), obs_cp2.size());
    end
    for (int i = 0; i < obs_cp1.size() && i < obs_cp2.size(); i++) begin
      total++;
      if (obs_cp1[i] !== 31'h41 || obs_cp2[i] !== 31'h41 || obs_fl1[i] !== 5'b0) begin
        bad++; $display("FAIL bp_entry[%0d] got %h/%h required 41", i, obs_cp1[i], obs_cp2[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ready_mode = 1;
    clear_obs();
    send('{8'hE2, 8'h82});
    @(negedge clk);
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (pending1 !== 1'b0 || out_valid1 !== 1'b0 || count1 !== 3'd0) begin
      bad++; $display("FAIL rstmid_state pending=%b valid=%b count=%0d required 0 0 0", pending1, out_valid1, count1);
    end
    rst_in = 1'b1;
    send('{8'h41});
    wait_drain();
    total++;
    if (obs_cp1.size() != 1 || obs_cp1[0] !== 31'h41 || obs_fl1[0] !== 5'b0 || obs_cp2.size() != 1) begin
      bad++; $display("FAIL rstmid_entry got n=%0d cp=%h required n=1 cp=41", obs_cp1.size(), obs_cp1.size() ? obs_cp1[0] : 31'h0);
    end
  endtask

  task automatic test_random();
    int items[$];
    ready_mode = 2;
    clear_obs();
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 6))
        0: items.push_back(int'($urandom_range(0, 127)));
        1: begin
          items.push_back(int'($urandom_range(8'hC0, 8'hDF)));
          items.push_back(int'($urandom_range(8'h80, 8'hBF)));
        end
        2: begin
          items.push_back(int'($urandom_range(8'hE0, 8'hEF)));
          repeat (2) items.push_back(int'($urandom_range(8'h80, 8'hBF)));
        end
        3: begin
          items.push_back(int'($urandom_range(8'hF0, 8'hF7)));
          repeat (3) items.push_back(int'($urandom_range(8'h80, 8'hBF)));
        end
        4: items.push_back(int'($urandom_range(0, 255)));
        5: items.push_back(-1);
        default: begin
          items.push_back(int'($urandom_range(8'hE0, 8'hF7)));
          items.push_back(int'($urandom_range(8'h80, 8'hBF)));
        end
      endcase
    end
    items.push_back(-1);
    model_run(items);
    send(items);
    ready_mode = 1;
    wait_drain();
    total++;
    if (obs_cp1.size() != exp_cp1.size() || obs_cp2.size() != exp_cp2.size() || count2 !== 3'd0) begin
      bad++; $display("FAIL rand_count got %0d/%0d required %0d", obs_cp1.size(), obs_cp2.size(), exp_cp1.size());
    end
    for (int i = 0; i < exp_cp1.size() && i < obs_cp1.size() && i < obs_cp2.size(); i++) begin
      total++;
      if (obs_cp1[i] !== exp_cp1[i] || obs_fl1[i] !== exp_fl1[i]) begin
        bad++; $display("FAIL rand_rep[%0d] got cp=%h fl=%b required cp=%h fl=%b", i, obs_cp1[i], obs_fl1[i], exp_cp1[i], exp_fl1[i]);
      end
      total++;
      if (obs_cp2[i] !== exp_cp2[i] || obs_fl2[i] !== exp_fl2[i]) begin
        bad++; $display("FAIL rand_raw[%0d] got cp=%h fl=%b required cp=%h fl=%b", i, obs_cp2[i], obs_fl2[i], exp_cp2[i], exp_fl2[i]);
      end
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data = 8'h0;
    flush = 1'b0;
    rst_in = 1'b0;
    test_reset();
    test_ascii();
    test_multibyte();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
